// File: rtl/spram_arbiter.sv
// Single-port SPRAM access scheduler: scan-out reads have priority, edge-detector
// writes are queued in a small FIFO and forced through after a bounded read streak.
module spram_arbiter #(
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned DATA_W        = 2,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned MAX_RD_STREAK = 8
) (
    input  logic                        mainClk,
    input  logic                        nreset,
    input  logic                        rdReq,
    input  logic [ADDR_W-1:0]           rdAddr,
    output logic                        rdGnt,
    output logic [DATA_W-1:0]           rdData,
    output logic                        rdDataValid,
    input  logic                        wrValid,
    input  logic [ADDR_W-1:0]           wrAddr,
    input  logic [DATA_W-1:0]           wrData,
    output logic                        wrReady,
    output logic [ADDR_W-1:0]           ramAddr,
    output logic [DATA_W-1:0]           ramWrData,
    output logic                        ramWe,
    input  logic [DATA_W-1:0]           ramRdData,
    output logic [$clog2(FIFO_DEPTH):0] fifoLevel
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned STK_W = $clog2(MAX_RD_STREAK + 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
    localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(MAX_RD_STREAK);

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic [STK_W-1:0]  r_streak;

    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_ram_we;
    logic              r_rd_pend;
    logic              r_rd_valid;

    logic              w_fifo_ne;
    logic              w_push;
    logic              w_rd_gnt;
    logic              w_wr_gnt;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    // Grant decisions use the level before this cycle's push, so a fresh entry waits a cycle.
    assign w_fifo_ne   = (r_level != '0);
    assign wrReady     = nreset && (r_level < LVL_FULL);
    assign w_push      = wrValid && wrReady;
    assign w_rd_gnt    = nreset && rdReq && !(w_fifo_ne && (r_streak == STREAK_MAX));
    assign w_wr_gnt    = nreset && w_fifo_ne && !w_rd_gnt;
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    assign rdGnt       = w_rd_gnt;
    assign rdData      = ramRdData;
    assign rdDataValid = r_rd_valid;
    assign ramAddr     = r_ram_addr;
    assign ramWrData   = r_ram_wdata;
    assign ramWe       = r_ram_we;
    assign fifoLevel   = r_level;

    always_ff @(posedge mainClk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= wrAddr;
            r_fifo_data[r_wptr] <= wrData;
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_streak <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_wr_gnt)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_wr_gnt})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: ;
            endcase
            // Streak only counts reads that overtook a waiting write.
            if (w_wr_gnt || !w_fifo_ne)
                r_streak <= '0;
            else if (w_rd_gnt && (r_streak != STREAK_MAX))
                r_streak <= r_streak + STK_W'(1);
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_pend  <= w_rd_gnt;
            r_rd_valid <= r_rd_pend;
            r_ram_we   <= w_wr_gnt;
            if (w_rd_gnt) begin
                r_ram_addr <= rdAddr;
            end else if (w_wr_gnt) begin
                r_ram_addr  <= w_head_addr;
                r_ram_wdata <= w_head_data;
            end
        end
    end
endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: fixed vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model with its own RAM image.
module tb_spram_arbiter;
    localparam int AW   = 19;
    localparam int DW   = 2;
    localparam int DEPTH = 4;
    localparam int MAXS = 8;

    logic          mainClk = 1'b0;
    logic          nreset  = 1'b0;
    logic          rdReq   = 1'b0;
    logic [AW-1:0] rdAddr  = '0;
    logic          wrValid = 1'b0;
    logic [AW-1:0] wrAddr  = '0;
    logic [DW-1:0] wrData  = '0;
    logic          rdGnt;
    logic [DW-1:0] rdData;
    logic          rdDataValid;
    logic          wrReady;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWrData;
    logic          ramWe;
    logic [DW-1:0] ramRdData;
    logic [2:0]    fifoLevel;

    spram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_RD_STREAK(MAXS)
    ) dut (
        .mainClk(mainClk), .nreset(nreset),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdGnt(rdGnt), .rdData(rdData), .rdDataValid(rdDataValid),
        .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData), .wrReady(wrReady),
        .ramAddr(ramAddr), .ramWrData(ramWrData), .ramWe(ramWe), .ramRdData(ramRdData),
        .fifoLevel(fifoLevel)
    );

    always #5 mainClk = ~mainClk;

    // Behavioural SPRAM: one-cycle read latency; bench addresses stay below 1024.
    logic [DW-1:0] ram [0:1023];
    always @(posedge mainClk) begin
        if (ramWe) ram[ramAddr[9:0]] <= ramWrData;
        ramRdData <= ram[ramAddr[9:0]];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t           q[$];
    int            streak;
    logic [DW-1:0] mmem [0:1023];
    logic          e_we, e_rdv1, e_rdv2;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rdd1, e_rdd2;
    logic          g_gnt, g_push;
    logic [AW-1:0] wlog[$];

    task automatic model_reset();
        q.delete();
        streak = 0;
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        e_rdv1 = 1'b0; e_rdv2 = 1'b0; e_rdd1 = '0; e_rdd2 = '0;
        for (int i = 0; i < 1024; i++) mmem[i] = ram[i];
    endtask

    // One clock cycle: drive, compare DUT against model, advance model.
    task automatic step(input logic rq, input logic [AW-1:0] ra, input logic wv,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic m_rdy, m_gnt, m_wgnt, nonempty;
        wr_t  w;
        @(posedge mainClk); #1;
        rdReq = rq; rdAddr = ra; wrValid = wv; wrAddr = wa; wrData = wd;
        #3;
        nonempty = (q.size() != 0);
        m_rdy  = (q.size() < DEPTH);
        m_gnt  = rq && !(nonempty && streak == MAXS);
        m_wgnt = nonempty && !m_gnt;
        chk("rdGnt", 32'(rdGnt), 32'(m_gnt));
        chk("wrReady", 32'(wrReady), 32'(m_rdy));
        chk("fifoLevel", 32'(fifoLevel), q.size());
        chk("ramWe", 32'(ramWe), 32'(e_we));
        chk("ramAddr", 32'(ramAddr), 32'(e_addr));
        if (e_we) chk("ramWrData", 32'(ramWrData), 32'(e_wd));
        chk("rdDataValid", 32'(rdDataValid), 32'(e_rdv2));
        if (e_rdv2) chk("rdData", 32'(rdData), 32'(e_rdd2));
        if (ramWe === 1'b1) wlog.push_back(ramAddr);
        e_rdv2 = e_rdv1; e_rdd2 = e_rdd1;
        e_rdv1 = m_gnt;  e_rdd1 = mmem[ra[9:0]];
        if (m_gnt) begin
            e_we = 1'b0; e_addr = ra;
        end else if (m_wgnt) begin
            w = q.pop_front();
            e_we = 1'b1; e_addr = w.a; e_wd = w.d;
            mmem[w.a[9:0]] = w.d;
        end else begin
            e_we = 1'b0;
        end
        if (m_wgnt || !nonempty) streak = 0;
        else if (m_gnt && streak < MAXS) streak++;
        g_push = wv && m_rdy;
        if (g_push) q.push_back('{a: wa, d: wd});
        g_gnt = m_gnt;
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge mainClk); #2;
        nreset = 1'b0;
        #1;
        chk({tag, "_ramWe"}, 32'(ramWe), 0);
        chk({tag, "_rdv"}, 32'(rdDataValid), 0);
        chk({tag, "_lvl"}, 32'(fifoLevel), 0);
        chk({tag, "_wrReady"}, 32'(wrReady), 0);
        chk({tag, "_rdGnt"}, 32'(rdGnt), 0);
        chk({tag, "_ramAddr"}, 32'(ramAddr), 0);
        chk({tag, "_ramWrData"}, 32'(ramWrData), 0);
        rdReq = 1'b0; wrValid = 1'b0;
        @(posedge mainClk); @(posedge mainClk); #3;
        nreset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic rq; logic [AW-1:0] ra; logic wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
        logic gnt; logic rdy; logic [2:0] lvl; logic we; logic [AW-1:0] addr;
        logic [DW-1:0] wdat; logic rdv; logic [DW-1:0] rdd;
    } vec_t;

    function automatic vec_t mk(input logic rq, input int ra, input logic wv, input int wa, input int wd,
                                input logic gnt, input logic rdy, input int lvl, input logic we,
                                input int addr, input int wdat, input logic rdv, input int rdd);
        vec_t v;
        v.rq = rq; v.ra = AW'(ra); v.wv = wv; v.wa = AW'(wa); v.wd = DW'(wd);
        v.gnt = gnt; v.rdy = rdy; v.lvl = 3'(lvl); v.we = we; v.addr = AW'(addr);
        v.wdat = DW'(wdat); v.rdv = rdv; v.rdd = DW'(rdd);
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tv[10];
        logic [AW-1:0] ra;
        logic          rq;
        int            k;

        for (int i = 0; i < 1024; i++) ram[i] <= '0;
        ram[10'h100] <= 2'b10;

        // Reset asserted from time zero; rdGnt must stay low even with a request.
        rdReq = 1'b1;
        #3;
        chk("rst0_ramWe", 32'(ramWe), 0);
        chk("rst0_rdv", 32'(rdDataValid), 0);
        chk("rst0_lvl", 32'(fifoLevel), 0);
        chk("rst0_wrReady", 32'(wrReady), 0);
        chk("rst0_rdGnt", 32'(rdGnt), 0);
        rdReq = 1'b0;
        #9 nreset = 1'b1;
        @(posedge mainClk); #1;
        chk("rel_wrReady", 32'(wrReady), 1);

        // Write-only burst then a single read of 0x100.
        tv[0] = mk(0, 0,     1, 5, 1,  0, 1, 0, 0, 0,     0, 0, 0);
        tv[1] = mk(0, 0,     1, 6, 2,  0, 1, 1, 0, 0,     0, 0, 0);
        tv[2] = mk(0, 0,     1, 7, 3,  0, 1, 1, 1, 5,     1, 0, 0);
        tv[3] = mk(0, 0,     0, 0, 0,  0, 1, 1, 1, 6,     2, 0, 0);
        tv[4] = mk(0, 0,     0, 0, 0,  0, 1, 0, 1, 7,     3, 0, 0);
        tv[5] = mk(0, 0,     0, 0, 0,  0, 1, 0, 0, 7,     0, 0, 0);
        tv[6] = mk(1, 'h100, 0, 0, 0,  1, 1, 0, 0, 7,     0, 0, 0);
        tv[7] = mk(0, 0,     0, 0, 0,  0, 1, 0, 0, 'h100, 0, 0, 0);
        tv[8] = mk(0, 0,     0, 0, 0,  0, 1, 0, 0, 'h100, 0, 1, 2);
        tv[9] = mk(0, 0,     0, 0, 0,  0, 1, 0, 0, 'h100, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge mainClk); #1;
            rdReq = tv[i].rq; rdAddr = tv[i].ra; wrValid = tv[i].wv; wrAddr = tv[i].wa; wrData = tv[i].wd;
            #3;
            chk($sformatf("tv%0d_rdGnt", i), 32'(rdGnt), 32'(tv[i].gnt));
            chk($sformatf("tv%0d_wrReady", i), 32'(wrReady), 32'(tv[i].rdy));
            chk($sformatf("tv%0d_lvl", i), 32'(fifoLevel), 32'(tv[i].lvl));
            chk($sformatf("tv%0d_ramWe", i), 32'(ramWe), 32'(tv[i].we));
            chk($sformatf("tv%0d_ramAddr", i), 32'(ramAddr), 32'(tv[i].addr));
            if (tv[i].we) chk($sformatf("tv%0d_ramWrData", i), 32'(ramWrData), 32'(tv[i].wdat));
            chk($sformatf("tv%0d_rdv", i), 32'(rdDataValid), 32'(tv[i].rdv));
            if (tv[i].rdv) chk($sformatf("tv%0d_rdData", i), 32'(rdData), 32'(tv[i].rdd));
        end

        // Starvation bound: continuous reads, one write pushed in cycle 0.
        pulse_reset("rstA");
        ra = AW'('h200);
        for (int c = 0; c <= 12; c++) begin
            step(1'b1, ra, c == 0, AW'('h30), 2'b11);
            if (c >= 1 && c <= 8) chk($sformatf("stv_gnt_c%0d", c), 32'(rdGnt), 1);
            if (c == 9) chk("stv_gnt_c9", 32'(rdGnt), 0);
            if (c == 10) begin
                chk("stv_we_c10", 32'(ramWe), 1);
                chk("stv_addr_c10", 32'(ramAddr), 'h30);
                chk("stv_gnt_c10", 32'(rdGnt), 1);
            end
            if (g_gnt) ra = ra + 1'b1;
        end

        // FIFO full under continuous reads; five writes offered back to back.
        pulse_reset("rstB");
        wlog.delete();
        ra = AW'('h300);
        k = 0;
        for (int c = 0; c < 60; c++) begin
            step(c < 50, ra, k < 5, AW'('h40 + k), DW'(k));
            if (c == 4) begin
                chk("full_wrReady_c4", 32'(wrReady), 0);
                chk("full_lvl_c4", 32'(fifoLevel), 4);
            end
            if (c == 9) begin
                chk("full_rdGnt_c9", 32'(rdGnt), 0);
                chk("full_wrReady_c9", 32'(wrReady), 0);
            end
            if (c == 10) begin
                chk("full_wrReady_c10", 32'(wrReady), 1);
                chk("full_lvl_c10", 32'(fifoLevel), 3);
            end
            if (g_push) k++;
            if (g_gnt) ra = ra + 1'b1;
        end
        chk("full_wcount", wlog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("full_order%0d", i), (i < wlog.size()) ? 32'(wlog[i]) : 32'hffff_ffff, 'h40 + i);

        // Reset with three queued writes and a read in flight.
        pulse_reset("rstC");
        for (int c = 0; c < 4; c++)
            step(1'b1, AW'('h280 + c), c < 3, AW'('h50 + c), 2'b01);
        chk("mid_lvl", 32'(fifoLevel), 3);
        pulse_reset("rstD");
        for (int c = 0; c < 20; c++) begin
            step(1'b0, '0, 1'b0, '0, '0);
            chk($sformatf("idle_we_c%0d", c), 32'(ramWe), 0);
        end

        // Randomized traffic; a pending read holds its address until granted.
        pulse_reset("rstE");
        rq = 1'b0; ra = '0; g_gnt = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!rq || g_gnt) begin
                rq = ($urandom_range(0, 3) != 0);
                ra = AW'($urandom_range(0, 63));
            end
            step(rq, ra, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 63)), DW'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
